// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, control codes, state types and sign-extension helper
package cpu_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] SSEL_REG   = 2'b00;
  localparam logic [1:0] SSEL_IMM   = 2'b01;
  localparam logic [1:0] SSEL_PCREL = 2'b10;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALTED} state_e;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP} pc_sel_e;

  // Replicates bit msb of v into every higher bit.
  function automatic logic [15:0] sext(input logic [15:0] v, input logic [3:0] msb);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = (i <= int'(msb)) ? v[i] : v[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// rtl/cpu_pc_unit.sv - program counter with hold / increment / relative branch / absolute jump
module cpu_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     pc_sel,
  input  logic [15:0] br_offset,
  input  logic [15:0] jmp_target,
  output logic [15:0] pc
);

  logic [15:0] r_pc;
  logic [15:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    case (pc_sel)
      PC_INC:    w_pc_next = r_pc + 16'd1;
      PC_BRANCH: w_pc_next = r_pc + br_offset;
      PC_JUMP:   w_pc_next = jmp_target;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_pc_next;
  end

  assign pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control unit for the 16-bit core
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [2:0]  RESET_NZP = 3'b010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [15:0] rf_rd_data1,
  input  logic [15:0] alu_result,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  output logic [2:0]  rf_dr,
  output logic        rf_we,
  output logic [1:0]  alu_op,
  output logic [1:0]  ssel,
  output logic [15:0] imm,
  output logic [2:0]  nzp,
  output logic        halted,
  output logic        illegal
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_ir;
  logic [2:0]  r_nzp;
  logic [15:0] w_pc;
  pc_sel_e     w_pc_sel;
  logic [3:0]  w_opcode;
  logic        w_alu_wr;
  logic        w_lea;
  logic        w_bad_op;
  logic        w_taken;
  logic        w_in_exec;

  assign w_opcode  = r_ir[15:12];
  assign w_in_exec = (r_state == EXECUTE);
  assign w_taken   = |(r_ir[11:9] & r_nzp);

  cpu_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_sel     (w_pc_sel),
    .br_offset  (sext({10'd0, r_ir[5:0]}, 4'd5)),
    .jmp_target (rf_rd_data1),
    .pc         (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (imem_ack) w_state_next = DECODE;
      DECODE:  w_state_next = EXECUTE;
      EXECUTE: w_state_next = (w_opcode == OP_HALT) ? HALTED : FETCH;
      HALTED:  w_state_next = HALTED;
      default: w_state_next = FETCH;
    endcase
  end

  // Decode is combinational off ir, so the control outputs stay put through DECODE and EXECUTE.
  always_comb begin
    rf_dr    = r_ir[11:9];
    rf_sr1   = r_ir[8:6];
    rf_sr2   = r_ir[2:0];
    alu_op   = ALU_ADD;
    ssel     = SSEL_REG;
    imm      = 16'h0000;
    w_alu_wr = 1'b0;
    w_lea    = 1'b0;
    w_bad_op = 1'b0;
    case (w_opcode)
      OP_ADD, OP_AND, OP_NOT: begin
        w_alu_wr = 1'b1;
        alu_op   = (w_opcode == OP_AND) ? ALU_AND :
                   (w_opcode == OP_NOT) ? ALU_NOT : ALU_ADD;
        if (r_ir[5]) begin
          ssel = SSEL_IMM;
          imm  = sext({11'd0, r_ir[4:0]}, 4'd4);
        end
      end
      OP_LEA: begin
        w_lea  = 1'b1;
        alu_op = ALU_PASS;
        ssel   = SSEL_PCREL;
        imm    = w_pc + sext({7'd0, r_ir[8:0]}, 4'd8);
      end
      OP_BR, OP_JMP, OP_HALT: ;
      default: w_bad_op = 1'b1;
    endcase

    w_pc_sel = PC_HOLD;
    if (r_state == FETCH && imem_ack)                      w_pc_sel = PC_INC;
    else if (w_in_exec && w_opcode == OP_BR && w_taken)    w_pc_sel = PC_BRANCH;
    else if (w_in_exec && w_opcode == OP_JMP)              w_pc_sel = PC_JUMP;

    // rst_n gates req directly because the state register reads FETCH during reset.
    imem_req = rst_n && (r_state == FETCH);
    rf_we    = w_in_exec && (w_alu_wr || w_lea);
    illegal  = w_in_exec && w_bad_op;
    halted   = (r_state == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir  <= 16'h0000;
      r_nzp <= RESET_NZP;
    end else begin
      if (r_state == FETCH && imem_ack) r_ir <= imem_data;
      if (w_in_exec && w_alu_wr)
        r_nzp <= {alu_result[15], alu_result == 16'h0000,
                  ~alu_result[15] && (alu_result != 16'h0000)};
    end
  end

  assign pc        = w_pc;
  assign imem_addr = w_pc;
  assign ir        = r_ir;
  assign nzp       = r_nzp;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] rf_rd_data1;
  logic [15:0] alu_result;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [2:0]  rf_sr1, rf_sr2, rf_dr;
  logic        rf_we;
  logic [1:0]  alu_op, ssel;
  logic [15:0] imm;
  logic [2:0]  nzp;
  logic        halted;
  logic        illegal;

  typedef struct packed {
    logic        we;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [1:0]  alu;
    logic [1:0]  ssel;
    logic [15:0] imm;
    logic        ill;
    logic [2:0]  nzp;
    logic [15:0] next_addr;
  } obs_t;

  obs_t obs, exp_v;
  obs_t sbq[$];
  logic stall_ok;
  int   vectors = 0;
  int   miscompares = 0;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_rd_data1(rf_rd_data1), .alu_result(alu_result),
    .pc(pc), .ir(ir), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_dr(rf_dr), .rf_we(rf_we),
    .alu_op(alu_op), .ssel(ssel), .imm(imm), .nzp(nzp), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic we, input logic [2:0] dr, sr1, sr2,
                              input logic [1:0] alu, sl, input logic [15:0] im,
                              input logic ill, input logic [2:0] cc, input logic [15:0] nxt);
    obs_t o;
    o = '{we: we, dr: dr, sr1: sr1, sr2: sr2, alu: alu, ssel: sl, imm: im,
          ill: ill, nzp: cc, next_addr: nxt};
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetches one word (after `stall` wait cycles), runs it, captures EXECUTE outputs and the following PC.
  task automatic exec_instr(input logic [15:0] word, input logic [15:0] ares,
                            input logic [15:0] rd1, input int stall);
    logic [15:0] a0;
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      obs = 'x;
      stall_ok = 1'b0;
      return;
    end
    stall_ok = 1'b1;
    a0 = imem_addr;
    imem_ack = 1'b0;
    repeat (stall) begin
      step();
      if (imem_addr !== a0 || imem_req !== 1'b1) stall_ok = 1'b0;
    end
    imem_ack = 1'b1;
    imem_data = word;
    step();
    imem_ack = 1'b0;
    alu_result = ares;
    rf_rd_data1 = rd1;
    step();
    obs.we = rf_we; obs.dr = rf_dr; obs.sr1 = rf_sr1; obs.sr2 = rf_sr2;
    obs.alu = alu_op; obs.ssel = ssel; obs.imm = imm; obs.ill = illegal;
    step();
    obs.nzp = nzp;
    obs.next_addr = imem_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_data = '0; rf_rd_data1 = '0; alu_result = '0;
    step(); step();
    vectors++;
    if ({imem_req, rf_we, illegal, halted} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/we/ill/halt got %b want 0000", {imem_req, rf_we, illegal, halted});
    end
    vectors++;
    if (pc !== 16'h0000 || ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pc_ir: got pc=%h ir=%h want 0000 0000", pc, ir);
    end
    vectors++;
    if (nzp !== 3'b010 || alu_op !== 2'b00 || ssel !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_nzp_op: got nzp=%b alu=%b ssel=%b want 010 00 00", nzp, alu_op, ssel);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_add();
    sbq.push_back(mk(1, 2, 2, 4, 2'b00, 2'b00, 16'h0000, 0, 3'b010, 16'h0001));
    exec_instr(16'h1484, 16'h0000, 16'h0000, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL add: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_addi();
    sbq.push_back(mk(1, 3, 2, 7, 2'b00, 2'b01, 16'h0007, 0, 3'b100, 16'h0002));
    exec_instr(16'h16A7, 16'hFFF9, 16'h0000, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL addi: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_branch();
    logic [15:0] w[6]  = '{16'h0000, 16'h0000, 16'h0000, 16'h083F, 16'h1484, 16'hC100};
    logic [15:0] ar[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0000};
    logic [15:0] rd[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
    sbq.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b100, 16'h0003));
    sbq.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b100, 16'h0004));
    sbq.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b100, 16'h0005));
    sbq.push_back(mk(0, 4, 0, 7, 2'b00, 2'b00, 16'h0000, 0, 3'b100, 16'h0005));
    sbq.push_back(mk(1, 2, 2, 4, 2'b00, 2'b00, 16'h0000, 0, 3'b001, 16'h0006));
    sbq.push_back(mk(0, 0, 4, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b001, 16'h0005));
    sbq.push_back(mk(0, 4, 0, 7, 2'b00, 2'b00, 16'h0000, 0, 3'b001, 16'h0006));
    for (int i = 0; i < 7; i++) begin
      if (i < 6) exec_instr(w[i], ar[i], rd[i], 0);
      else       exec_instr(16'h083F, 16'h0000, 16'h0000, 0);
      exp_v = sbq.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_jmp();
    sbq.push_back(mk(0, 0, 4, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b001, 16'h1234));
    exec_instr(16'hC100, 16'h0000, 16'h1234, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL jmp: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_lea_illegal();
    sbq.push_back(mk(0, 0, 4, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b001, 16'h0010));
    sbq.push_back(mk(1, 2, 0, 2, 2'b11, 2'b10, 16'h0013, 0, 3'b001, 16'h0011));
    sbq.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 1, 3'b001, 16'h0012));
    exec_instr(16'hC100, 16'h0000, 16'h0010, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL jmp_to_lea: got %h want %h", obs, exp_v);
    end
    exec_instr(16'hE402, 16'hAAAA, 16'h0000, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL lea: got %h want %h", obs, exp_v);
    end
    exec_instr(16'hD000, 16'h0000, 16'h0000, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL illegal: got %h want %h", obs, exp_v);
    end
    vectors++;
    if (illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse: got %b after execute want 0", illegal);
    end
  endtask

  task automatic test_stall_reset();
    sbq.push_back(mk(1, 2, 2, 4, 2'b00, 2'b00, 16'h0000, 0, 3'b010, 16'h0013));
    exec_instr(16'h1484, 16'h0000, 16'h0000, 5);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL stall_instr: got %h want %h", obs, exp_v);
    end
    vectors++;
    if (stall_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_addr: addr/req stable=%b want 1", stall_ok);
    end
    imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || pc !== 16'h0000 || rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got req=%b pc=%h we=%b want 0 0000 0", imem_req, pc, rf_we);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_halt();
    logic ok = 1'b1;
    sbq.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 3'b010, 16'h0001));
    exec_instr(16'hF000, 16'h0000, 16'h0000, 0);
    exp_v = sbq.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL halt_instr: got %h want %h", obs, exp_v);
    end
    imem_ack = 1'b1;
    imem_data = 16'h1484;
    repeat (10) begin
      if (halted !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 || pc !== 16'h0001) ok = 1'b0;
      step();
    end
    imem_ack = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL halted_hold: stayed halted=%b want 1", ok);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_branch();
    test_jmp();
    test_lea_illegal();
    test_stall_reset();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
